// File: rtl/iob_be_ram_arbiter_if.sv
// Manager-side IOb bus of the RAM arbiter: request channel in,
// ready/read-response channel out, all managers flattened.
interface iob_be_ram_arbiter_if #(
   parameter int NMGR   = 2,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [NMGR-1:0]            m_valid;
   logic [NMGR*ADDR_W-1:0]     m_addr;
   logic [NMGR*DATA_W-1:0]     m_wdata;
   logic [NMGR*DATA_W/8-1:0]   m_wstrb;
   logic [NMGR-1:0]            m_ready;
   logic [NMGR-1:0]            m_rvalid;
   logic [NMGR*DATA_W-1:0]     m_rdata;

   modport master (
      output m_valid, m_addr, m_wdata, m_wstrb,
      input  m_ready, m_rvalid, m_rdata
   );

   modport slave (
      input  m_valid, m_addr, m_wdata, m_wstrb,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/iob_be_ram_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enable RAM between
// NMGR IOb managers, with bounded burst locks and read-response routing.
module iob_be_ram_arbiter #(
   parameter int NMGR      = 2,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   iob_be_ram_arbiter_if.slave m_if,
   output logic                mem_en_o,
   output logic [DATA_W/8-1:0] mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_d_o,
   input  logic [DATA_W-1:0]   mem_d_i
);
   localparam int IDX_W  = $clog2(NMGR);
   localparam int CNT_W  = $clog2(MAX_BURST + 1);
   localparam int STRB_W = DATA_W / 8;

   logic [IDX_W-1:0]  r_last;
   logic [IDX_W-1:0]  r_owner;
   logic              r_lock;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rd_valid;
   logic [IDX_W-1:0]  r_rd_owner;

   logic              w_lock_hit;
   logic              w_gnt_vld;
   logic [IDX_W-1:0]  w_gnt;
   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  w_sel;
   logic              w_acc;
   logic [STRB_W-1:0] w_strb;
   logic              w_is_rd;
   logic [CNT_W-1:0]  w_cnt_new;
   logic              w_burst_end;

   // Grant: a live lock keeps its owner, else first valid after last.
   always_comb begin
      w_lock_hit = r_lock && m_if.m_valid[r_owner];
      w_gnt_vld  = 1'b0;
      w_gnt      = '0;
      w_idx      = '0;
      if (w_lock_hit) begin
         w_gnt_vld = 1'b1;
         w_gnt     = r_owner;
      end else begin
         // Walk from farthest to nearest so the nearest valid wins.
         for (int i = NMGR; i >= 1; i--) begin
            w_idx = IDX_W'((int'(r_last) + i) % NMGR);
            if (m_if.m_valid[w_idx]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = w_idx;
            end
         end
      end
   end

   // Request mux onto the RAM port; stall and reset block acceptance.
   always_comb begin
      w_acc      = w_gnt_vld && cke_i && !rst_i;
      w_sel      = (w_gnt_vld && !rst_i) ? w_gnt : '0;
      w_strb     = m_if.m_wstrb[int'(w_sel)*STRB_W +: STRB_W];
      w_is_rd    = (w_strb == '0);
      mem_en_o   = w_acc;
      mem_we_o   = w_acc ? w_strb : '0;
      mem_addr_o = m_if.m_addr[int'(w_sel)*ADDR_W +: ADDR_W];
      mem_d_o    = m_if.m_wdata[int'(w_sel)*DATA_W +: DATA_W];
      m_if.m_ready = '0;
      if (w_acc) begin
         m_if.m_ready[w_gnt] = 1'b1;
      end
   end

   // Burst length after this accept; restarts on a new owner.
   always_comb begin
      if (r_cnt == '0 || r_owner != w_gnt) begin
         w_cnt_new = CNT_W'(1);
      end else begin
         w_cnt_new = r_cnt + CNT_W'(1);
      end
      w_burst_end = (w_cnt_new == CNT_W'(MAX_BURST));
   end

   // Read response to its owner; reset swallows a pending response.
   always_comb begin
      m_if.m_rvalid = '0;
      if (r_rd_valid && !rst_i) begin
         m_if.m_rvalid[r_rd_owner] = 1'b1;
      end
      m_if.m_rdata = {NMGR{mem_d_i}};
   end

   // Round-robin pointer, lock and burst counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last  <= IDX_W'(NMGR - 1);
         r_owner <= '0;
         r_lock  <= 1'b0;
         r_cnt   <= '0;
      end else if (cke_i) begin
         if (w_acc) begin
            r_last  <= w_gnt;
            r_owner <= w_gnt;
            if (w_burst_end) begin
               r_lock <= 1'b0;
               r_cnt  <= '0;
            end else begin
               r_lock <= 1'b1;
               r_cnt  <= w_cnt_new;
            end
         end else begin
            // No grant means the owner dropped valid: release.
            r_lock <= 1'b0;
         end
      end
   end

   // Track which manager the RAM data returns to next cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_valid <= 1'b0;
         r_rd_owner <= '0;
      end else if (cke_i) begin
         r_rd_valid <= w_acc && w_is_rd;
         if (w_acc) begin
            r_rd_owner <= w_gnt;
         end
      end
   end
endmodule
